// File: rtl/mod12_stim_sequencer_if.sv
// Command port of the mod-12 stimulus sequencer: valid/ready handshake carrying an op and argument.
interface mod12_stim_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_arg;

  modport master (output cmd_valid, cmd_op, cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_arg, output cmd_ready);
endinterface

// File: rtl/mod12_stim_sequencer.sv
// Drives load/mode/datain of a mod-MOD up/down counter from queued commands and checks its
// dataout against a cycle-exact internal copy of the counter.
module mod12_stim_sequencer #(
  parameter int ERR_W = 8,
  parameter int MOD   = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  mod12_stim_sequencer_if.slave cmd,
  output logic                 cnt_load,
  output logic                 cnt_mode,
  output logic [3:0]           cnt_datain,
  input  logic [3:0]           cnt_dataout,
  output logic [3:0]           exp_count,
  output logic                 busy,
  output logic                 done,
  output logic                 mismatch,
  output logic                 illegal,
  output logic [ERR_W-1:0]     err_cnt
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_WAIT = 2'b11;
  localparam logic [3:0] MAX_VAL = 4'(MOD - 1);
  localparam logic [4:0] MOD_W   = 5'(MOD);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t           state_q;
  logic [3:0]       remain_q;
  logic             cnt_load_q;
  logic             cnt_mode_q;
  logic [3:0]       cnt_datain_q;
  logic [3:0]       exp_q;
  logic [3:0]       exp_d;
  logic             busy_q;
  logic             done_q;
  logic             mismatch_q;
  logic             illegal_q;
  logic             armed_q;
  logic [ERR_W-1:0] err_q;
  logic             accept;

  // Model advances from the same registered controls the counter sees, so it tracks even when idle.
  always_comb begin
    exp_d = exp_q;
    if (cnt_load_q) begin
      exp_d = cnt_datain_q;
    end else if (cnt_mode_q) begin
      exp_d = (exp_q == MAX_VAL) ? 4'd0 : exp_q + 4'd1;
    end else begin
      exp_d = (exp_q == 4'd0) ? MAX_VAL : exp_q - 4'd1;
    end
  end

  assign cmd.cmd_ready = (state_q == S_IDLE) && rst;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      remain_q     <= 4'd0;
      cnt_load_q   <= 1'b0;
      cnt_mode_q   <= 1'b1;
      cnt_datain_q <= 4'd0;
      exp_q        <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mismatch_q   <= 1'b0;
      illegal_q    <= 1'b0;
      armed_q      <= 1'b0;
      err_q        <= '0;
    end else begin
      exp_q  <= exp_d;
      done_q <= 1'b0;

      // Checking stays off until a LOAD has put the counter in a known state.
      if (armed_q && (cnt_dataout != exp_q)) begin
        mismatch_q <= 1'b1;
        if (err_q != '1) err_q <= err_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (cmd.cmd_op == OP_LOAD) begin
              if ({1'b0, cmd.cmd_arg} < MOD_W) begin
                cnt_load_q   <= 1'b1;
                cnt_datain_q <= cmd.cmd_arg;
                state_q      <= S_LOAD;
              end else begin
                illegal_q <= 1'b1;
                done_q    <= 1'b1;
              end
            end else begin
              if (cmd.cmd_op != OP_WAIT) cnt_mode_q <= (cmd.cmd_op == OP_UP);
              if (cmd.cmd_arg == 4'd0) begin
                done_q <= 1'b1;
              end else begin
                remain_q <= cmd.cmd_arg;
                busy_q   <= 1'b1;
                state_q  <= S_RUN;
              end
            end
          end
        end
        S_LOAD: begin
          cnt_load_q <= 1'b0;
          armed_q    <= 1'b1;
          done_q     <= 1'b1;
          state_q    <= S_IDLE;
        end
        S_RUN: begin
          remain_q <= remain_q - 4'd1;
          if (remain_q == 4'd1) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cnt_load   = cnt_load_q;
  assign cnt_mode   = cnt_mode_q;
  assign cnt_datain = cnt_datain_q;
  assign exp_count  = exp_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign mismatch   = mismatch_q;
  assign illegal    = illegal_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_mod12_stim_sequencer.sv
// Bench for mod12_stim_sequencer: counter stub with fault injection, behavioural model, per-cycle compare.
module tb_mod12_stim_sequencer;
  localparam int MOD     = 12;
  localparam int ERR_W   = 8;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mod12_stim_sequencer_if cmd_if();

  logic             cnt_load, cnt_mode, busy, done, mismatch, illegal;
  logic [3:0]       cnt_datain, cnt_dataout, exp_count;
  logic [ERR_W-1:0] err_cnt;

  mod12_stim_sequencer #(.ERR_W(ERR_W), .MOD(MOD)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if.slave),
    .cnt_load(cnt_load), .cnt_mode(cnt_mode), .cnt_datain(cnt_datain),
    .cnt_dataout(cnt_dataout), .exp_count(exp_count), .busy(busy), .done(done),
    .mismatch(mismatch), .illegal(illegal), .err_cnt(err_cnt)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Counter stub: never reset, so its start value is unknown to the sequencer.
  int         cyc = 0;
  int         fault_until = 0;
  logic [3:0] stub_q = 4'd7;
  assign cnt_dataout = (cyc < fault_until) ? (stub_q ^ 4'h5) : stub_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cnt_load)      stub_q <= cnt_datain;
    else if (cnt_mode) stub_q <= 4'((int'(stub_q) + 1) % MOD);
    else               stub_q <= 4'((int'(stub_q) + MOD - 1) % MOD);
  end

  // Behavioural model: m_hold = cycles the sequencer stays unavailable, m_kind = what completes then.
  int m_hold = 0, m_kind = 0, m_datain = 0, m_exp = 0, m_err = 0, m_nexp = 0;
  bit m_load = 0, m_mode = 1, m_busy = 0, m_done = 0, m_mis = 0, m_ill = 0, m_armed = 0, m_acc = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_hold = 0; m_kind = 0; m_datain = 0; m_exp = 0; m_err = 0;
      m_load = 0; m_mode = 1; m_busy = 0; m_done = 0; m_mis = 0; m_ill = 0; m_armed = 0;
    end else begin
      m_acc  = cmd_if.cmd_valid && (m_hold == 0);
      m_nexp = m_load ? m_datain : (m_mode ? (m_exp + 1) % MOD : (m_exp + MOD - 1) % MOD);
      if (m_armed && int'(cnt_dataout) != m_exp) begin
        m_mis = 1;
        if (m_err < ERR_MAX) m_err++;
      end
      m_done = 0;
      if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) begin
          m_done = 1;
          m_busy = 0;
          if (m_kind == 1) begin m_load = 0; m_armed = 1; end
        end
      end else if (m_acc) begin
        if (cmd_if.cmd_op == 2'd0) begin
          if (int'(cmd_if.cmd_arg) < MOD) begin
            m_load = 1; m_datain = int'(cmd_if.cmd_arg); m_hold = 1; m_kind = 1;
          end else begin
            m_ill = 1; m_done = 1;
          end
        end else begin
          if (cmd_if.cmd_op == 2'd1) m_mode = 1;
          if (cmd_if.cmd_op == 2'd2) m_mode = 0;
          if (cmd_if.cmd_arg == 4'd0) m_done = 1;
          else begin m_hold = int'(cmd_if.cmd_arg); m_busy = 1; m_kind = 2; end
        end
      end
      m_exp = m_nexp;
    end
  end

  // One compare per cycle of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (cmd_if.cmd_ready !== ((m_hold == 0) && rst) || cnt_load !== m_load || cnt_mode !== m_mode ||
          cnt_datain !== 4'(m_datain) || exp_count !== 4'(m_exp) || busy !== m_busy || done !== m_done ||
          mismatch !== m_mis || illegal !== m_ill || err_cnt !== ERR_W'(m_err)) begin
        miscompares++;
        $display("FAIL cycle_compare @%0t got rdy=%b ld=%b md=%b di=%0d exp=%0d bsy=%b dn=%b mis=%b ill=%b err=%0d, need rdy=%b ld=%b md=%b di=%0d exp=%0d bsy=%b dn=%b mis=%b ill=%b err=%0d",
                 $time, cmd_if.cmd_ready, cnt_load, cnt_mode, cnt_datain, exp_count, busy, done, mismatch,
                 illegal, err_cnt, (m_hold == 0) && rst, m_load, m_mode, m_datain, m_exp, m_busy, m_done,
                 m_mis, m_ill, m_err);
      end
    end
  end

  task automatic check(input string name, input int got, input int need);
    vectors++;
    if (got != need) begin
      miscompares++;
      $display("FAIL %s got=%0d need=%0d @%0t", name, got, need, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [1:0] op, input logic [3:0] a);
    int n;
    n = 0;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_arg   = a;
    cmd_if.cmd_valid = 1'b1;
    while (!cmd_if.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_if.cmd_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout op=%0d arg=%0d ready never rose @%0t", op, a, $time);
      cmd_if.cmd_valid = 1'b0;
    end else begin
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
    end
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'd0;
    cmd_if.cmd_arg   = 4'd0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_ready", int'(cmd_if.cmd_ready), 0);
    check("reset_mode", int'(cnt_mode), 1);
    check("reset_exp", int'(exp_count), 0);
    check("reset_err", int'(err_cnt), 0);
    #2 rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", int'(cmd_if.cmd_ready), 1);

    send(2'd0, 4'd5);
    check("load5_pulse", int'(cnt_load), 1);
    check("load5_datain", int'(cnt_datain), 5);
    @(negedge clk);
    check("load5_exp", int'(exp_count), 5);
    check("load5_done", int'(done), 1);
    check("load5_load_low", int'(cnt_load), 0);

    send(2'd0, 4'd10);
    send(2'd1, 4'd3);
    check("up_wrap_11", int'(exp_count), 11);
    @(negedge clk);
    check("up_wrap_0", int'(exp_count), 0);
    @(negedge clk);
    check("up_wrap_1", int'(exp_count), 1);
    check("up_busy3", int'(busy), 1);
    @(negedge clk);
    check("up_done", int'(done), 1);
    check("up_busy_end", int'(busy), 0);

    send(2'd2, 4'd0);
    send(2'd0, 4'd1);
    send(2'd2, 4'd3);
    check("down_wrap_0", int'(exp_count), 0);
    @(negedge clk);
    check("down_wrap_11", int'(exp_count), 11);
    @(negedge clk);
    check("down_wrap_10", int'(exp_count), 10);
    check("down_no_mismatch", int'(mismatch), 0);

    send(2'd0, 4'd12);
    check("illegal_flag", int'(illegal), 1);
    check("illegal_done", int'(done), 1);
    check("illegal_no_load", int'(cnt_load), 0);

    fault_until = cyc + 3;
    repeat (4) @(negedge clk);
    check("fault_mismatch", int'(mismatch), 1);
    check("fault_err3", int'(err_cnt), 3);

    send(2'd1, 4'd10);
    repeat (6) @(negedge clk);
    check("pre_reset_busy", int'(busy), 1);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_err", int'(err_cnt), 0);
    check("abort_mismatch", int'(mismatch), 0);
    check("abort_exp", int'(exp_count), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("abort_ready", int'(cmd_if.cmd_ready), 1);
    fault_until = cyc + 4;
    repeat (5) @(negedge clk);
    check("unarmed_no_mismatch", int'(mismatch), 0);

    send(2'd0, 4'($urandom_range(0, MOD - 1)));
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) fault_until = cyc + 1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end

    fault_until = cyc + 300;
    repeat (305) @(negedge clk);
    check("err_saturated", int'(err_cnt), ERR_MAX);
    check("mismatch_sticky", int'(mismatch), 1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
